vga_sync_rx: RTL

Receive-side counterpart to the `vga640x480` timing generator. It samples incoming `hs`/`vs` on the pixel strobe and rebuilds the pixel coordinates and active-video flag from the sync edges alone. It checks every line and frame length against the configured timing, and reports lock and timing errors. It sits on the sink side of a VGA link, or in loopback behind the generator for self-check, and feeds coordinate-driven logic such as pixel capture and overlay.

---
 rtl/vga_sync_rx.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: rebuilds pixel coordinates from hs/vs edges, measures line/frame lengths, tracks lock.
// Define VGA_RX_INSYNC_EN to pass i_hs/i_vs through a two-flop synchronizer before edge detection.
module vga_sync_rx #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pix_stb,
  input  logic        i_hs,
  input  logic        i_vs,
  output logic [9:0]  o_x,
  output logic [8:0]  o_y,
  output logic        o_active,
  output logic        o_locked,
  output logic        o_frame_start,
  output logic        o_err,
  output logic [10:0] o_line_len,
  output logic [9:0]  o_frame_lines
);

  localparam int unsigned HW = 11;
  localparam int unsigned VW = 10;
  localparam int unsigned XW = 10;
  localparam int unsigned YW = 9;
  localparam int unsigned GW = 3;

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_ASTART = H_SYNC + H_BP;
  localparam int unsigned V_ASTART = V_SYNC + V_BP;

  localparam logic [HW-1:0] H_TOTAL_C  = HW'(H_TOTAL);
  localparam logic [VW-1:0] V_TOTAL_C  = VW'(V_TOTAL);
  localparam logic [HW-1:0] H_ASTART_C = HW'(H_ASTART);
  localparam logic [HW-1:0] H_AEND_C   = HW'(H_ASTART + H_ACTIVE);
  localparam logic [VW-1:0] V_ASTART_C = VW'(V_ASTART);
  localparam logic [VW-1:0] V_AEND_C   = VW'(V_ASTART + V_ACTIVE);
  localparam logic [HW-1:0] H_MAX      = '1;
  localparam logic [VW-1:0] V_MAX      = '1;
  localparam logic [GW-1:0] LOCK_C     = GW'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  logic hs_s, vs_s;

`ifdef VGA_RX_INSYNC_EN
  // Two-flop synchronizers; idle-high so reset never looks like a sync edge.
  logic [1:0] hs_sync_q, hs_sync_d, vs_sync_q, vs_sync_d;

  always_comb begin
    hs_sync_d = {hs_sync_q[0], i_hs};
    vs_sync_d = {vs_sync_q[0], i_vs};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hs_sync_q <= 2'b11;
      vs_sync_q <= 2'b11;
    end else begin
      hs_sync_q <= hs_sync_d;
      vs_sync_q <= vs_sync_d;
    end
  end

  assign hs_s = hs_sync_q[1];
  assign vs_s = vs_sync_q[1];
`else
  assign hs_s = i_hs;
  assign vs_s = i_vs;
`endif

  state_e          state_q, state_d;
  logic            hs_q, hs_d, vs_q, vs_d;
  logic            vs_pend_q, vs_pend_d;
  logic            frame_bad_q, frame_bad_d;
  logic [GW-1:0]   gf_q, gf_d;
  logic [HW-1:0]   h_cnt_q, h_cnt_d;
  logic [VW-1:0]   v_cnt_q, v_cnt_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            active_q, active_d;
  logic            locked_q, locked_d;
  logic            frame_start_q, frame_start_d;
  logic            err_q, err_d;
  logic [HW-1:0]   line_len_q, line_len_d;
  logic [VW-1:0]   frame_lines_q, frame_lines_d;

  logic hs_fall, vs_fall, restart, bad_line, bad_frame, in_region;

  // Per-strobe edge detection, counting, lock FSM and output staging.
  always_comb begin
    state_d       = state_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    vs_pend_d     = vs_pend_q;
    frame_bad_d   = frame_bad_q;
    gf_d          = gf_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    x_d           = x_q;
    y_d           = y_q;
    active_d      = active_q;
    locked_d      = locked_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    frame_start_d = 1'b0;
    err_d         = 1'b0;
    hs_fall       = 1'b0;
    vs_fall       = 1'b0;
    restart       = 1'b0;
    bad_line      = 1'b0;
    bad_frame     = 1'b0;
    in_region     = 1'b0;

    if (i_pix_stb) begin
      hs_fall  = hs_q & ~hs_s;
      vs_fall  = vs_q & ~vs_s;
      hs_d     = hs_s;
      vs_d     = vs_s;
      restart  = hs_fall & (vs_pend_q | vs_fall);
      bad_line = hs_fall & ((h_cnt_q + 11'd1) != H_TOTAL_C);

      if (hs_fall) begin
        h_cnt_d    = '0;
        line_len_d = h_cnt_q + 11'd1;
      end else if (h_cnt_q != H_MAX) begin
        h_cnt_d = h_cnt_q + 11'd1;
      end

      if (vs_fall) vs_pend_d = 1'b1;

      // A pending vsync is honoured at the next hsync edge so v_cnt stays line-aligned.
      if (restart) begin
        v_cnt_d       = '0;
        vs_pend_d     = 1'b0;
        frame_lines_d = v_cnt_q + 10'd1;
        frame_start_d = 1'b1;
      end else if (hs_fall && (v_cnt_q != V_MAX)) begin
        v_cnt_d = v_cnt_q + 10'd1;
      end

      bad_frame = restart & (frame_bad_q | bad_line | ((v_cnt_q + 10'd1) != V_TOTAL_C));
      if (restart)       frame_bad_d = 1'b0;
      else if (bad_line) frame_bad_d = 1'b1;

      case (state_q)
        SEARCH: begin
          if (restart) begin
            state_d = TRACK;
            gf_d    = '0;
          end
        end
        TRACK: begin
          if (restart) begin
            if (bad_frame) begin
              gf_d = '0;
            end else begin
              gf_d = gf_q + 3'd1;
              if (gf_d == LOCK_C) state_d = LOCKED;
            end
          end
        end
        LOCKED: begin
          if (bad_line || bad_frame || (h_cnt_d == H_MAX) || (v_cnt_d == V_MAX)) begin
            err_d   = 1'b1;
            state_d = SEARCH;
          end
        end
        default: state_d = SEARCH;
      endcase

      in_region = (h_cnt_d >= H_ASTART_C) && (h_cnt_d < H_AEND_C) &&
                  (v_cnt_d >= V_ASTART_C) && (v_cnt_d < V_AEND_C);
      x_d       = in_region ? XW'(h_cnt_d - H_ASTART_C) : '0;
      y_d       = in_region ? YW'(v_cnt_d - V_ASTART_C) : '0;
      locked_d  = (state_d == LOCKED);
      active_d  = in_region && (state_d == LOCKED);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= SEARCH;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      vs_pend_q     <= 1'b0;
      frame_bad_q   <= 1'b0;
      gf_q          <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      active_q      <= 1'b0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      err_q         <= 1'b0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
    end else begin
      state_q       <= state_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      vs_pend_q     <= vs_pend_d;
      frame_bad_q   <= frame_bad_d;
      gf_q          <= gf_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= active_d;
      locked_q      <= locked_d;
      frame_start_q <= frame_start_d;
      err_q         <= err_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
    end
  end

  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_active      = active_q;
  assign o_locked      = locked_q;
  assign o_frame_start = frame_start_q;
  assign o_err         = err_q;
  assign o_line_len    = line_len_q;
  assign o_frame_lines = frame_lines_q;

endmodule
